// File: rtl/flag_ctrl.sv
// -----------------------------------------------------------------------------
// flag_ctrl
//
// Purpose:
//   Carry/zero flag pipeline for a simple in-order core. The execute stage
//   produces candidate flags; they travel through two in-flight stages
//   (S1 = MEM, S2 = WB) before being committed to the architectural flags.
//   The flags seen by the EX condition check are forwarded from the youngest
//   in-flight writer, falling back to the committed value.
//
// Ports:
//   clk         in   system clock, rising-edge state updates
//   rst_n       in   asynchronous active-low reset
//   ex_valid    in   instruction present in EX
//   ex_opcode   in   [3:0] EX opcode (selects which flags are written)
//   ex_funct    in   [1:0] EX condition field (already folded into ex_wb_en)
//   ex_wb_en    in   writeback enable after conditional squash
//   ex_c_new    in   ALU carry out
//   ex_z_new    in   zero result (ALU or load data)
//   stall       in   EX held: bubble into S1
//   flush       in   kill EX instruction: bubble into S1
//   c_flag      out  forwarded carry for the EX condition check
//   z_flag      out  forwarded zero for the EX condition check
//   arch_c      out  committed carry
//   arch_z      out  committed zero
//   commit_cnt  out  [7:0] number of committed flag updates (wraps)
// -----------------------------------------------------------------------------
module flag_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic [3:0] ex_opcode,
    input  logic [1:0] ex_funct,
    input  logic       ex_wb_en,
    input  logic       ex_c_new,
    input  logic       ex_z_new,
    input  logic       stall,
    input  logic       flush,
    output logic       c_flag,
    output logic       z_flag,
    output logic       arch_c,
    output logic       arch_z,
    output logic [7:0] commit_cnt
);

    typedef struct packed {
        logic wc;
        logic wz;
        logic c;
        logic z;
    } stage_t;

    // Returns {write_c, write_z} for an opcode.
    function automatic logic [1:0] decode_we(input logic [3:0] opcode);
        logic [1:0] we;
        case (opcode)
            4'b0000, 4'b0001: we = 2'b11;   // ADD family, ADI
            4'b0010, 4'b0100: we = 2'b01;   // NAND family, LW
            default:          we = 2'b00;
        endcase
        return we;
    endfunction

    stage_t     s1_q, s1_d;
    stage_t     s2_q, s2_d;
    logic       arch_c_q, arch_c_d;
    logic       arch_z_q, arch_z_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ex_we_s;

    // The condition field is resolved upstream into ex_wb_en; it is kept on
    // the port list for interface completeness only.
    logic       unused_funct_s;
    assign unused_funct_s = ^ex_funct;

    // EX write enables: squashed or absent instructions write nothing.
    always_comb begin
        ex_we_s = 2'b00;
        if (ex_valid && ex_wb_en) begin
            ex_we_s = decode_we(ex_opcode);
        end else begin
            ex_we_s = 2'b00;
        end
    end

    // Next-state for the flag pipeline, commit and commit counter.
    always_comb begin
        s1_d     = stage_t'(4'b0000);
        s2_d     = s1_q;            // S1 always advances; flush never touches S2
        arch_c_d = arch_c_q;
        arch_z_d = arch_z_q;
        cnt_d    = cnt_q;

        if (stall || flush) begin
            s1_d = stage_t'(4'b0000);
        end else begin
            s1_d = '{wc: ex_we_s[1], wz: ex_we_s[0], c: ex_c_new, z: ex_z_new};
        end

        if (s2_q.wc) begin
            arch_c_d = s2_q.c;
        end else begin
            arch_c_d = arch_c_q;
        end

        if (s2_q.wz) begin
            arch_z_d = s2_q.z;
        end else begin
            arch_z_d = arch_z_q;
        end

        if (s2_q.wc || s2_q.wz) begin
            cnt_d = cnt_q + 8'd1;   // natural 8-bit wrap 255 -> 0
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous clear; reset drops in-flight updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= stage_t'(4'b0000);
            s2_q     <= stage_t'(4'b0000);
            arch_c_q <= 1'b0;
            arch_z_q <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            arch_c_q <= arch_c_d;
            arch_z_q <= arch_z_d;
            cnt_q    <= cnt_d;
        end
    end

    // Forwarding: youngest in-flight writer wins, else the committed flag.
    // The EX candidate is deliberately not forwarded.
    always_comb begin
        c_flag = 1'b0;
        z_flag = 1'b0;
        if (s1_q.wc) begin
            c_flag = s1_q.c;
        end else if (s2_q.wc) begin
            c_flag = s2_q.c;
        end else begin
            c_flag = arch_c_q;
        end

        if (s1_q.wz) begin
            z_flag = s1_q.z;
        end else if (s2_q.wz) begin
            z_flag = s2_q.z;
        end else begin
            z_flag = arch_z_q;
        end
    end

    assign arch_c     = arch_c_q;
    assign arch_z     = arch_z_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flag_ctrl
//
// Self-checking bench for flag_ctrl. Each clock edge's stimulus is recorded as
// an "effective update" in a history list; the expected outputs are computed
// from that history (forwarded flags = latest writer issued so far, committed
// flags = latest writer issued at least three edges ago) and queued. A
// separate monitor pops the queue every cycle and compares.
// -----------------------------------------------------------------------------
module tb_flag_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [1:0] ex_funct;
    logic       ex_wb_en;
    logic       ex_c_new;
    logic       ex_z_new;
    logic       stall;
    logic       flush;
    logic       c_flag;
    logic       z_flag;
    logic       arch_c;
    logic       arch_z;
    logic [7:0] commit_cnt;

    flag_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_funct   (ex_funct),
        .ex_wb_en   (ex_wb_en),
        .ex_c_new   (ex_c_new),
        .ex_z_new   (ex_z_new),
        .stall      (stall),
        .flush      (flush),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .arch_c     (arch_c),
        .arch_z     (arch_z),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit wc;
        bit wz;
        bit c;
        bit z;
    } upd_t;

    typedef struct {
        bit       cf;
        bit       zf;
        bit       ac;
        bit       az;
        bit [7:0] cnt;
    } exp_t;

    upd_t hist[$];      // one entry per clock edge since the last reset
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Expected outputs from the whole update history since reset.
    function automatic exp_t model();
        exp_t e;
        int   k;
        int   n;
        k = hist.size();
        e.cf = 1'b0; e.zf = 1'b0; e.ac = 1'b0; e.az = 1'b0;
        n = 0;
        for (int i = 0; i < k; i++) begin
            if (hist[i].wc) e.cf = hist[i].c;
            if (hist[i].wz) e.zf = hist[i].z;
        end
        for (int i = 0; i < k - 2; i++) begin
            if (hist[i].wc) e.ac = hist[i].c;
            if (hist[i].wz) e.az = hist[i].z;
            if (hist[i].wc || hist[i].wz) n++;
        end
        e.cnt = 8'(n % 256);
        return e;
    endfunction

    // One clock of stimulus; records the update and queues the expectation.
    task automatic step(input bit v, input bit [3:0] op, input bit [1:0] fn,
                        input bit wb, input bit c, input bit z,
                        input bit st, input bit fl);
        upd_t u;
        bit   live;
        @(negedge clk);
        ex_valid = v; ex_opcode = op; ex_funct = fn; ex_wb_en = wb;
        ex_c_new = c; ex_z_new = z; stall = st; flush = fl;
        @(posedge clk);
        #1;
        live = v && wb && !st && !fl;
        u.wc = live && (op == 4'd0 || op == 4'd1);
        u.wz = live && (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd4);
        u.c  = c;
        u.z  = z;
        hist.push_back(u);
        exp_q.push_back(model());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Mid-cycle asynchronous reset, with a live writer in EX to be discarded.
    task automatic do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_opcode = 4'd0; ex_wb_en = 1'b1;
        ex_c_new = 1'b1; ex_z_new = 1'b1; stall = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_c_flag", c_flag, 0);
        check("rst_z_flag", z_flag, 0);
        check("rst_arch_c", arch_c, 0);
        check("rst_arch_z", arch_z, 0);
        check("rst_cnt", commit_cnt, 0);
        hist.delete();
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: compares queued expectations against the DUT every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("c_flag", c_flag, e.cf);
                check("z_flag", z_flag, e.zf);
                check("arch_c", arch_c, e.ac);
                check("arch_z", arch_z, e.az);
                check("commit_cnt", commit_cnt, e.cnt);
            end
        end
    end

    initial begin
        bit [3:0] op;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_opcode = 4'd0; ex_funct = 2'd0; ex_wb_en = 1'b0;
        ex_c_new = 1'b0; ex_z_new = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        check("init_c_flag", c_flag, 0);
        check("init_arch_c", arch_c, 0);
        check("init_cnt", commit_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD c=1 z=0: c_flag next cycle, commit after three edges.
        step(1'b1, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("add_c_fwd", c_flag, 1);
        idle(2);
        check("add_arch_c", arch_c, 1);
        check("add_cnt", commit_cnt, 1);

        // Squashed ADC from a clean state changes nothing.
        do_reset();
        step(1'b1, 4'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("adc_sq_cnt", commit_cnt, 0);
        check("adc_sq_arch_z", arch_z, 0);

        // ADD c=1 z=1 then NDU z=0: C from S2, Z from S1 together.
        step(1'b1, 4'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("add_ndu_c", c_flag, 1);
        check("add_ndu_z", z_flag, 0);
        idle(3);
        check("add_ndu_arch_c", arch_c, 1);
        check("add_ndu_arch_z", arch_z, 0);

        // LW under flush, LW under stall, LW under both: no update.
        step(1'b1, 4'd4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4'd4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'd4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);
        check("lw_killed_arch_z", arch_z, 0);
        check("lw_killed_cnt", commit_cnt, 2);

        // 256 ADI writers wrap the counter to zero.
        do_reset();
        for (int i = 0; i < 256; i++)
            step(1'b1, 4'd1, 2'b00, 1'b1, 1'(i & 1), 1'(i >> 1 & 1), 1'b0, 1'b0);
        idle(2);
        check("adi_wrap_cnt", commit_cnt, 0);

        // Reset mid-stream, then no stale commit on the first edges.
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'd1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        idle(3);
        check("post_rst_cnt", commit_cnt, 0);
        check("post_rst_arch_c", arch_c, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 4))
                    0:       op = 4'd0;
                    1:       op = 4'd1;
                    2:       op = 4'd2;
                    3:       op = 4'd4;
                    default: op = 4'($urandom_range(0, 15));
                endcase
                step(1'($urandom_range(0, 7) != 0), op, 2'($urandom_range(0, 2)),
                     1'($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
            end
        end
        idle(4);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
